delta_scan_arbiter: RTL
=======================

DELTA_SCAN_ARBITER -- requirements
Module: delta_scan_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, meaning the number of delta-register channels served (legal range 2..32).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning the width of each channel's value.
REQ-003 SHALL have port CLK, input, 1 bit, meaning the clock; all logic is rising-edge.
REQ-004 SHALL have port RSTN, input, 1 bit, meaning reset, synchronous, active-low.
REQ-005 SHALL have port ENABLE, input, 1 bit, meaning that new grants are allowed while high.
REQ-006 SHALL have port CHG_IN, input, NUM_CH bits, meaning the per-channel change flags from the delta registers.
REQ-007 SHALL have port VALUE_IN, input, NUM_CH*DATA_WIDTH bits, meaning the per-channel values; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have port READ_ACK, output, NUM_CH bits, meaning a one-hot read strobe that drives each channel's read event.
REQ-009 SHALL have port EVT_VALID, output, 1 bit, meaning the event output is valid.
REQ-010 SHALL have port EVT_READY, input, 1 bit, meaning the consumer accepts the event.
REQ-011 SHALL have port EVT_CH, output, $clog2(NUM_CH) bits, meaning the index of the channel that produced the event.
REQ-012 SHALL have port EVT_DATA, output, DATA_WIDTH bits, meaning the captured channel value.

Function
REQ-013 SHALL implement the FSM states IDLE, ACK and HOLD.
REQ-014 IDLE: when ENABLE=1 and (CHG_IN & eligible) is non-zero, SHALL select as winner the first set bit at index >= rr_ptr, wrapping to index 0, and go to ACK on the next edge.
REQ-015 IDLE with no eligible request or ENABLE=0: SHALL stay in IDLE, with READ_ACK=0 and EVT_VALID=0.
REQ-016 ACK (exactly 1 cycle): SHALL drive READ_ACK[winner]=1 with all other bits 0; at the closing edge SHALL latch EVT_DATA from the VALUE_IN slice of the winner, set EVT_CH=winner, set EVT_VALID=1, set rr_ptr=(winner+1) mod NUM_CH, and go to HOLD.
REQ-017 HOLD: SHALL hold EVT_VALID, EVT_CH and EVT_DATA stable with READ_ACK=0; on EVT_READY=1, EVT_VALID SHALL clear at that edge and the FSM SHALL go to IDLE.
REQ-018 Latency: with CHG_IN seen in IDLE in cycle N, READ_ACK SHALL be high in cycle N+1 and EVT_VALID SHALL be high from cycle N+2; minimum spacing is 3 cycles per event.
REQ-019 READ_ACK SHALL never have more than one bit set, and SHALL never be high outside ACK.
REQ-020 A CHG_IN bit falling between selection and ACK SHALL NOT abort the grant; the ACK pulse and event SHALL still be issued.
REQ-021 CHG_IN changes during HOLD SHALL be ignored until IDLE is re-entered; the flags stay latched in the delta registers, so no event is lost.
REQ-022 ENABLE deasserting in ACK or HOLD SHALL NOT abort that event; it only blocks the next selection.
REQ-023 EVT_READY in IDLE or ACK SHALL have no effect.
REQ-024 rr_ptr SHALL wrap from NUM_CH-1 to 0, so that every continuously requesting channel is served within NUM_CH events.

Reset
REQ-025 While RSTN=0 at an edge, the block SHALL go to IDLE with rr_ptr=0, READ_ACK=0, EVT_VALID=0, EVT_CH=0 and EVT_DATA=0.
REQ-026 Reset asserted in ACK or HOLD SHALL drop the in-flight event without issuing a further READ_ACK.

Configuration
REQ-027 The macro DELTA_SCAN_ARBITER_MASK_EN SHALL control channel masking.
REQ-028 With DELTA_SCAN_ARBITER_MASK_EN defined, the block SHALL add input port CH_MASK (NUM_CH bits), and eligible SHALL be ~CH_MASK, so that masked channels are never granted.
REQ-029 Without DELTA_SCAN_ARBITER_MASK_EN, CH_MASK SHALL be absent and eligible SHALL be all ones.

Verification
REQ-030 The bench SHALL cover: NUM_CH=4, CHG_IN=0100, VALUE_IN ch2=0xDEADBEEF, EVT_READY=1 -> READ_ACK=0100 for 1 cycle, then EVT_VALID=1, EVT_CH=2, EVT_DATA=0xDEADBEEF, then rr_ptr=3.
REQ-031 The bench SHALL cover: CHG_IN=1111 held, EVT_READY=1 -> grant order 0,1,2,3,0 with one event every 3 cycles.
REQ-032 The bench SHALL cover: EVT_READY=0 for 10 cycles with CHG_IN=0011 -> a single event held stable, no second READ_ACK; after READ_READY is raised, ch1 is granted next.
REQ-033 The bench SHALL cover: ENABLE=0 with CHG_IN=1000 -> no READ_ACK; after ENABLE=1, READ_ACK=1000 one cycle later.
REQ-034 The bench SHALL cover: RSTN=0 during HOLD -> EVT_VALID=0 on the next edge, rr_ptr=0, state IDLE.
REQ-035 The bench SHALL cover, with MASK_EN: CH_MASK=0001 and CHG_IN=0011 -> only ch1 is granted and ch0 is never acknowledged.

Source files
------------

// File: rtl/delta_scan_arbiter.sv
// Round-robin scanner over delta-register change flags: grants one channel, pulses its
// read strobe, captures its value and holds it as a valid/ready event. Optional masking via DELTA_SCAN_ARBITER_MASK_EN.
module delta_scan_arbiter #(
    parameter int NUM_CH     = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                             CLK,
    input  logic                             RSTN,
    input  logic                             ENABLE,
    input  logic [NUM_CH-1:0]                CHG_IN,
`ifdef DELTA_SCAN_ARBITER_MASK_EN
    input  logic [NUM_CH-1:0]                CH_MASK,
`endif
    input  logic [NUM_CH*DATA_WIDTH-1:0]     VALUE_IN,
    output logic [NUM_CH-1:0]                READ_ACK,
    output logic                             EVT_VALID,
    input  logic                             EVT_READY,
    output logic [$clog2(NUM_CH)-1:0]        EVT_CH,
    output logic [DATA_WIDTH-1:0]            EVT_DATA
);

    localparam int CH_W = $clog2(NUM_CH);

    typedef enum logic [1:0] {IDLE, ACK, HOLD} state_t;

    state_t                state_q, state_d;
    logic [CH_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [CH_W-1:0]       winner_q, winner_d;
    logic [NUM_CH-1:0]     read_ack_q, read_ack_d;
    logic                  evt_valid_q, evt_valid_d;
    logic [CH_W-1:0]       evt_ch_q, evt_ch_d;
    logic [DATA_WIDTH-1:0] evt_data_q, evt_data_d;

    logic [NUM_CH-1:0]     eligible;
    logic [NUM_CH-1:0]     req;
    logic                  found_hi, found_any;
    logic [CH_W-1:0]       low_hi, low_any;
    logic                  sel_found;
    logic [CH_W-1:0]       sel_idx;
    logic [DATA_WIDTH-1:0] win_data;

`ifdef DELTA_SCAN_ARBITER_MASK_EN
    assign eligible = ~CH_MASK;
`else
    assign eligible = '1;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_req
            assign req[gi] = CHG_IN[gi] & eligible[gi];
        end
    endgenerate

    // Scanning downward leaves the lowest index in each candidate: lowest at/after
    // the pointer wins, otherwise the lowest overall (the wrap-around case).
    always_comb begin
        found_hi  = 1'b0;
        found_any = 1'b0;
        low_hi    = '0;
        low_any   = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (req[i]) begin
                found_any = 1'b1;
                low_any   = CH_W'(i);
                if (CH_W'(i) >= rr_ptr_q) begin
                    found_hi = 1'b1;
                    low_hi   = CH_W'(i);
                end
            end
        end
        sel_found = found_any;
        sel_idx   = found_hi ? low_hi : low_any;
    end

    always_comb begin
        win_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (winner_q == CH_W'(i)) begin
                win_data = VALUE_IN[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        winner_d    = winner_q;
        read_ack_d  = '0;
        evt_valid_d = evt_valid_q;
        evt_ch_d    = evt_ch_q;
        evt_data_d  = evt_data_q;
        case (state_q)
            IDLE: begin
                if (ENABLE && sel_found) begin
                    state_d    = ACK;
                    winner_d   = sel_idx;
                    read_ack_d = {{(NUM_CH-1){1'b0}}, 1'b1} << sel_idx;
                end
            end
            ACK: begin
                // Value is sampled as the strobe closes, so the delta register has
                // already seen its read event.
                state_d     = HOLD;
                evt_valid_d = 1'b1;
                evt_ch_d    = winner_q;
                evt_data_d  = win_data;
                rr_ptr_d    = (winner_q == CH_W'(NUM_CH - 1)) ? '0 : winner_q + CH_W'(1);
            end
            HOLD: begin
                if (EVT_READY) begin
                    state_d     = IDLE;
                    evt_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            winner_q    <= '0;
            read_ack_q  <= '0;
            evt_valid_q <= 1'b0;
            evt_ch_q    <= '0;
            evt_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            winner_q    <= winner_d;
            read_ack_q  <= read_ack_d;
            evt_valid_q <= evt_valid_d;
            evt_ch_q    <= evt_ch_d;
            evt_data_q  <= evt_data_d;
        end
    end

    assign READ_ACK  = read_ack_q;
    assign EVT_VALID = evt_valid_q;
    assign EVT_CH    = evt_ch_q;
    assign EVT_DATA  = evt_data_q;

endmodule
